systolic_feed_ctrl: RTL and testbench

- Sequences one matrix multiply C = A x B on the systolic PE grid.
- Captures A (ARRAY_W x ARRAY_L) and B (ARRAY_L x ARRAY_H) from the ROM-style parallel sources in one cycle.
- Drives the left and top grid edges with diagonally skewed operands, waits for the last PE to accumulate, then pulses done.
- Sits between the roma/romb data sources and the PE array; issues the accumulator clear.

---
 rtl/sa_pkg.sv | 10 +
 rtl/sa_edge_skew.sv | 24 ++
 rtl/systolic_feed_ctrl.sv | 91 +++++++++
 tb/tb_systolic_feed_ctrl.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/sa_pkg.sv
// sa_pkg: shared FSM state type and schedule-length helpers for systolic_feed_ctrl
package sa_pkg;
  typedef enum logic [1:0] {IDLE, CLEAR, RUN, DONE} state_t;
  function automatic int calc_t_last(int w, int l, int h, int lat);
    return l + w + h - 3 + lat;
  endfunction
  function automatic int cnt_width(int t_last);
    return (t_last < 1) ? 1 : $clog2(t_last + 1);
  endfunction
endpackage

// File: rtl/sa_edge_skew.sv
// sa_edge_skew: diagonal skew of N lanes of L-deep operands (in: data, t, en; out: edge_val, valid), lane n emits data[n][t-n] while 0 <= t-n < L
module sa_edge_skew #(
  parameter int N = 5,
  parameter int L = 2,
  parameter int DW = 8,
  parameter int TW = 4
) (
  input  logic [0:N-1][0:L-1][DW-1:0] data,
  input  logic [TW-1:0]               t,
  input  logic                        en,
  output logic [0:N-1][DW-1:0]        edge_val,
  output logic [0:N-1]                valid
);
  always_comb begin
    edge_val = '0;
    valid = '0;
    for (int n = 0; n < N; n++)
      for (int k = 0; k < L; k++)
        if (en && int'(t) == n + k) begin
          edge_val[n] = data[n][k];
          valid[n] = 1'b1;
        end
  end
endmodule

// File: rtl/systolic_feed_ctrl.sv
// systolic_feed_ctrl: sequences one C=AxB on the PE grid (in: clk, reset, start, input_data_a/b; out: skewed a/b edges+valids, pe_clear, busy, done; SYSTOLIC_CYCLE_COUNT_EN adds cycle_count)
module systolic_feed_ctrl
  import sa_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ARRAY_W = 5,
  parameter int ARRAY_L = 2,
  parameter int ARRAY_H = 5,
  parameter int PE_LAT = 1
) (
  input  logic                                           clk,
  input  logic                                           reset,
  input  logic                                           start,
  input  logic [0:ARRAY_W-1][0:ARRAY_L-1][DATA_WIDTH-1:0] input_data_a,
  input  logic [0:ARRAY_L-1][0:ARRAY_H-1][DATA_WIDTH-1:0] input_data_b,
  output logic [0:ARRAY_W-1][DATA_WIDTH-1:0]              a_edge,
  output logic [0:ARRAY_W-1]                              a_valid,
  output logic [0:ARRAY_H-1][DATA_WIDTH-1:0]              b_edge,
  output logic [0:ARRAY_H-1]                              b_valid,
  output logic                                           pe_clear,
  output logic                                           busy,
  output logic                                           done
`ifdef SYSTOLIC_CYCLE_COUNT_EN
  ,
  output logic [31:0]                                    cycle_count
`endif
);
  localparam int T_LAST = calc_t_last(ARRAY_W, ARRAY_L, ARRAY_H, PE_LAT);
  localparam int TW = cnt_width(T_LAST);
  localparam logic [TW-1:0] T_END = TW'(T_LAST);
  state_t state, state_n;
  logic [TW-1:0] t;
  logic [0:ARRAY_W-1][0:ARRAY_L-1][DATA_WIDTH-1:0] a_q;
  logic [0:ARRAY_L-1][0:ARRAY_H-1][DATA_WIDTH-1:0] b_q;
  logic [0:ARRAY_H-1][0:ARRAY_L-1][DATA_WIDTH-1:0] b_t;
  logic [0:ARRAY_W-1][DATA_WIDTH-1:0] a_sk;
  logic [0:ARRAY_H-1][DATA_WIDTH-1:0] b_sk;
  logic [0:ARRAY_W-1] a_v;
  logic [0:ARRAY_H-1] b_v;
  always_comb begin
    b_t = '0;
    for (int j = 0; j < ARRAY_H; j++)
      for (int k = 0; k < ARRAY_L; k++)
        b_t[j][k] = b_q[k][j];
  end
  sa_edge_skew #(.N(ARRAY_W), .L(ARRAY_L), .DW(DATA_WIDTH), .TW(TW)) u_a_skew (
    .data(a_q), .t(t), .en(state == RUN), .edge_val(a_sk), .valid(a_v)
  );
  sa_edge_skew #(.N(ARRAY_H), .L(ARRAY_L), .DW(DATA_WIDTH), .TW(TW)) u_b_skew (
    .data(b_t), .t(t), .en(state == RUN), .edge_val(b_sk), .valid(b_v)
  );
  always_comb begin
    state_n = state;
    state_n = state == IDLE  ? (start ? CLEAR : IDLE) :
              state == CLEAR ? RUN :
              state == RUN   ? (t == T_END ? DONE : RUN) : IDLE;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      t <= '0;
      a_q <= '0;
      b_q <= '0;
      a_edge <= '0;
      a_valid <= '0;
      b_edge <= '0;
      b_valid <= '0;
      pe_clear <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      state <= state_n;
      t <= state == RUN ? t + 1'b1 : '0;
      if (state == IDLE && start) begin
        a_q <= input_data_a;
        b_q <= input_data_b;
      end
      a_edge <= a_sk;
      a_valid <= a_v;
      b_edge <= b_sk;
      b_valid <= b_v;
      pe_clear <= state == CLEAR;
      busy <= state != IDLE;
      done <= state == DONE;
    end
  end
`ifdef SYSTOLIC_CYCLE_COUNT_EN
  always_ff @(posedge clk)
    cycle_count <= reset || state == CLEAR ? '0 : busy ? cycle_count + 32'd1 : cycle_count;
`endif
endmodule

// File: tb/tb_systolic_feed_ctrl.sv
// tb_systolic_feed_ctrl: scoreboard bench, expected output frames queued at start and compared every cycle
module tb_systolic_feed_ctrl;
  localparam int W = 5, L = 2, H = 5, DW = 8, LAT = 1;
  localparam int T_LAST = W + L + H - 3 + LAT;
  typedef logic [0:W-1][0:L-1][DW-1:0] mat_a_t;
  typedef logic [0:L-1][0:H-1][DW-1:0] mat_b_t;
  typedef struct packed {
    logic [0:W-1][DW-1:0] ae;
    logic [0:W-1]         av;
    logic [0:H-1][DW-1:0] be;
    logic [0:H-1]         bv;
    logic                 pc;
    logic                 bu;
    logic                 dn;
  } frame_t;
  logic clk = 0, reset = 0, start = 0;
  mat_a_t in_a, a_std;
  mat_b_t in_b, b_std;
  logic [0:W-1][DW-1:0] a_edge;
  logic [0:W-1] a_valid;
  logic [0:H-1][DW-1:0] b_edge;
  logic [0:H-1] b_valid;
  logic pe_clear, busy, done;
`ifdef SYSTOLIC_CYCLE_COUNT_EN
  logic [31:0] cycle_count;
`endif
  frame_t q[$];
  int n_cmp = 0, n_bad = 0;
  always #5 clk = ~clk;
  systolic_feed_ctrl #(.DATA_WIDTH(DW), .ARRAY_W(W), .ARRAY_L(L), .ARRAY_H(H), .PE_LAT(LAT)) dut (
    .clk(clk), .reset(reset), .start(start),
    .input_data_a(in_a), .input_data_b(in_b),
    .a_edge(a_edge), .a_valid(a_valid), .b_edge(b_edge), .b_valid(b_valid),
    .pe_clear(pe_clear), .busy(busy), .done(done)
`ifdef SYSTOLIC_CYCLE_COUNT_EN
    , .cycle_count(cycle_count)
`endif
  );
  task automatic push_op(input mat_a_t a, input mat_b_t b);
    frame_t f;
    q.push_back('0);
    f = '0; f.pc = 1; f.bu = 1; q.push_back(f);
    for (int t = 0; t <= T_LAST; t++) begin
      f = '0; f.bu = 1;
      for (int i = 0; i < W; i++)
        if (t - i >= 0 && t - i < L) begin f.ae[i] = a[i][t-i]; f.av[i] = 1; end
      for (int j = 0; j < H; j++)
        if (t - j >= 0 && t - j < L) begin f.be[j] = b[t-j][j]; f.bv[j] = 1; end
      q.push_back(f);
    end
    f = '0; f.bu = 1; f.dn = 1; q.push_back(f);
  endtask
  task automatic tick(output frame_t act, output frame_t exp);
    @(posedge clk); #1;
    exp = q.size() > 0 ? q.pop_front() : frame_t'('0);
    act = {a_edge, a_valid, b_edge, b_valid, pe_clear, busy, done};
  endtask
  task automatic test_reset();
    frame_t act, exp;
    reset = 1;
    tick(act, exp);
    reset = 0;
    n_cmp++;
    if (act !== exp) begin n_bad++; $display("FAIL reset: got %h want %h", act, exp); end
    repeat (5) begin
      tick(act, exp);
      n_cmp++;
      if (act !== exp) begin n_bad++; $display("FAIL idle: got %h want %h", act, exp); end
    end
  endtask
  task automatic test_single();
    frame_t act, exp;
    in_a = a_std; in_b = b_std;
    start = 1;
    push_op(a_std, b_std);
    for (int c = 0; c < 16; c++) begin
      tick(act, exp);
      start = 0;
      n_cmp++;
      if (act !== exp) begin n_bad++; $display("FAIL single c%0d: got %h want %h", c, act, exp); end
      n_cmp++;
      if (done !== (c == 13)) begin n_bad++; $display("FAIL done_timing c%0d: got %b want %b", c, done, c == 13); end
      if (c == 2) begin
        n_cmp++;
        if (a_edge[0] !== 8'd1 || a_valid !== 5'b10000 || b_edge[0] !== 8'd20 || b_valid !== 5'b10000) begin
          n_bad++; $display("FAIL t0_spot: got a0=%0d av=%b b0=%0d bv=%b want 1 10000 20 10000", a_edge[0], a_valid, b_edge[0], b_valid);
        end
      end
      if (c == 7) begin
        n_cmp++;
        if (a_edge[4] !== 8'd42 || a_valid !== 5'b00001) begin
          n_bad++; $display("FAIL t5_spot: got a4=%0d av=%b want 42 00001", a_edge[4], a_valid);
        end
      end
    end
  endtask
  task automatic test_back_to_back();
    frame_t act, exp;
    start = 1;
    push_op(a_std, b_std);
    push_op(a_std, b_std);
    for (int c = 0; c < 32; c++) begin
      tick(act, exp);
      if (c == 26) start = 0;
      n_cmp++;
      if (act !== exp) begin n_bad++; $display("FAIL b2b c%0d: got %h want %h", c, act, exp); end
    end
  endtask
  task automatic test_capture();
    frame_t act, exp;
    mat_a_t ff;
    ff = '1;
    in_a = a_std;
    start = 1;
    push_op(a_std, b_std);
    for (int c = 0; c < 15; c++) begin
      tick(act, exp);
      start = 0;
      if (c == 3) in_a = ff;
      n_cmp++;
      if (act !== exp) begin n_bad++; $display("FAIL capture c%0d: got %h want %h", c, act, exp); end
    end
    in_a = a_std;
  endtask
  task automatic test_random();
    frame_t act, exp;
    mat_a_t ra;
    mat_b_t rb;
    repeat (3) begin
      for (int i = 0; i < W; i++) for (int k = 0; k < L; k++) ra[i][k] = DW'($urandom);
      for (int k = 0; k < L; k++) for (int j = 0; j < H; j++) rb[k][j] = DW'($urandom);
      in_a = ra; in_b = rb;
      start = 1;
      push_op(ra, rb);
      for (int c = 0; c < 15; c++) begin
        tick(act, exp);
        start = 0;
        in_a = ~ra; in_b = ~rb;
        n_cmp++;
        if (act !== exp) begin n_bad++; $display("FAIL random c%0d: got %h want %h", c, act, exp); end
      end
    end
    in_a = a_std; in_b = b_std;
  endtask
  task automatic test_reset_mid();
    frame_t act, exp;
    start = 1;
    push_op(a_std, b_std);
    for (int c = 0; c < 6; c++) begin
      tick(act, exp);
      start = 0;
      n_cmp++;
      if (act !== exp) begin n_bad++; $display("FAIL pre_reset c%0d: got %h want %h", c, act, exp); end
    end
    reset = 1;
    q.delete();
    tick(act, exp);
    reset = 0;
    n_cmp++;
    if (act !== exp) begin n_bad++; $display("FAIL mid_reset: got %h want %h", act, exp); end
    for (int c = 0; c < 10; c++) begin
      tick(act, exp);
      n_cmp++;
      if (act !== exp || done !== 1'b0) begin n_bad++; $display("FAIL post_reset c%0d: got %h want %h", c, act, exp); end
    end
    start = 1;
    push_op(a_std, b_std);
    for (int c = 0; c < 15; c++) begin
      tick(act, exp);
      start = 0;
      n_cmp++;
      if (act !== exp) begin n_bad++; $display("FAIL restart c%0d: got %h want %h", c, act, exp); end
    end
  endtask
`ifdef SYSTOLIC_CYCLE_COUNT_EN
  task automatic test_cycle_count();
    frame_t act, exp;
    start = 1;
    push_op(a_std, b_std);
    repeat (17) begin tick(act, exp); start = 0; end
    n_cmp++;
    if (cycle_count !== 32'd13) begin n_bad++; $display("FAIL cc_final: got %0d want 13", cycle_count); end
    start = 1;
    push_op(a_std, b_std);
    repeat (2) begin tick(act, exp); start = 0; end
    n_cmp++;
    if (cycle_count !== 32'd0) begin n_bad++; $display("FAIL cc_clear: got %0d want 0", cycle_count); end
    repeat (14) tick(act, exp);
  endtask
`endif
  initial begin
    for (int i = 0; i < W; i++) for (int k = 0; k < L; k++) a_std[i][k] = DW'(10 * i + k + 1);
    for (int k = 0; k < L; k++) for (int j = 0; j < H; j++) b_std[k][j] = DW'(20 + 10 * k + j);
    in_a = a_std; in_b = b_std;
    test_reset();
    test_single();
    test_back_to_back();
    test_capture();
    test_random();
    test_reset_mid();
`ifdef SYSTOLIC_CYCLE_COUNT_EN
    test_cycle_count();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
